// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst reader and its skid buffer.
//   rd_state_t  : reader FSM states
//   SKID_DEPTH  : entries in the output skid buffer
//   cnt_width() : width of a counter that must hold 0..burst_len
//   ptr_inc()   : circular pointer increment over SKID_DEPTH entries
package fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_t;

  localparam int SKID_DEPTH = 3;

  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/skid_buf3.sv
// Three-entry circular buffer that absorbs the FIFO read latency so the
// stream can keep moving under backpressure.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en      : write wr_data at the tail this edge (caller never overfills)
//   rd_valid   : buffer non-empty; rd_data is the head entry
//   rd_ready   : consumer takes the head entry when rd_valid is also high
//   occupancy  : number of stored entries (0..3)
module skid_buf3
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [1:0]            count;
  logic                  deq;

  assign deq       = rd_valid && rd_ready;
  assign rd_valid  = (count != 2'd0);
  assign rd_data   = mem[head];
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 2'd0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= ptr_inc(tail);
      end
      if (deq) head <= ptr_inc(head);
      // Simultaneous write and dequeue leaves the count unchanged.
      case ({wr_en, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for sync_fifo: on a start pulse it drains exactly
// BURST_LEN words and presents them as a valid/ready stream with m_last on
// the final beat.
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle burst request, ignored while busy
//   busy            : burst in progress (FSM in RUN)
//   burst_done      : one-cycle pulse the cycle after the last handshake
//   fifo_empty      : FIFO empty flag
//   fifo_rd_en      : FIFO read strobe (combinational from state + empty)
//   fifo_dout       : FIFO data, valid one cycle after an effective read
//   m_valid/m_ready : stream handshake, m_data/m_last carried with it
// Handshake: a beat transfers on any rising edge where m_valid && m_ready;
// once m_valid is high it stays high with m_data stable until that edge.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  burst_done,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int            CW   = cnt_width(BURST_LEN);
  localparam logic [CW-1:0] BL_C = CW'(BURST_LEN);

  rd_state_t     state;
  rd_state_t     state_nxt;
  logic [CW-1:0] issued;
  logic [CW-1:0] sent;
  logic          inflight;
  logic          done_q;
  logic [1:0]    occ;
  logic          hs;
  logic          last_hs;

  // Registered occupancy plus the word still in flight from the FIFO must
  // leave room; a same-cycle dequeue is deliberately not credited.
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (issued < BL_C) &&
                      (({1'b0, occ} + {2'b00, inflight}) < 3'(SKID_DEPTH));

  assign hs         = m_valid && m_ready;
  assign m_last     = m_valid && (sent == BL_C - 1'b1);
  assign last_hs    = hs && m_last;
  assign busy       = (state == RUN);
  assign burst_done = done_q;

  skid_buf3 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (inflight),
    .wr_data   (fifo_dout),
    .rd_ready  (m_ready),
    .rd_valid  (m_valid),
    .rd_data   (m_data),
    .occupancy (occ)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = RUN;
      RUN:     if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      issued   <= '0;
      sent     <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      done_q   <= last_hs;
      if (state == IDLE && start) begin
        issued <= '0;
        sent   <= '0;
      end else begin
        if (fifo_rd_en) issued <= issued + 1'b1;
        if (hs)         sent   <= sent + 1'b1;
      end
    end
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side master for `sync_fifo`. On a `start` pulse it drains exactly `BURST_LEN` words from the FIFO and presents them as a valid/ready stream, marking the final beat with `m_last`. It sits between the FIFO's `rd_en`/`dout`/`empty` port and a downstream consumer. It absorbs the FIFO's one-cycle read latency and sustains one beat per cycle under downstream backpressure.

## Interface
- `DATA_WIDTH`, 8: width of FIFO words and stream data.
- `BURST_LEN`, 8: beats per burst; legal range is 1..255.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle request to begin one burst; ignored while `busy`.
- `busy`  out  1: high from the cycle after an accepted `start` until the cycle after the last beat's handshake.
- `burst_done`  out  1: one-cycle pulse in the cycle after the last-beat handshake.
- `fifo_empty`  in  1: FIFO `empty`.
- `fifo_rd_en`  out  1: FIFO `rd_en`; combinational from registered state and `fifo_empty`.
- `fifo_dout`  in  `DATA_WIDTH`: FIFO `dout`; valid one cycle after a cycle with `fifo_rd_en && !fifo_empty`.
- `m_valid`  out  1: stream data valid.
- `m_ready`  in  1: consumer ready.
- `m_data`  out  `DATA_WIDTH`: stream data.
- `m_last`  out  1: high with the `BURST_LEN`-th beat.

## Operation
- Two states, IDLE and RUN.
  - IDLE -> RUN on `start`.
  - RUN -> IDLE on the handshake (`m_valid && m_ready`) of the beat with `m_last`.
- Counters:
  - `issued` counts reads issued in the current burst.
  - `sent` counts beats handshaken in the current burst.
  - Both are `$clog2(BURST_LEN+1)` bits wide and clear on entry to RUN.
- Skid buffer: 3-entry circular buffer with head/tail pointers and a 2-bit occupancy count. `inflight` flag is 1 when a read was issued in the previous cycle.
- Read issue: `fifo_rd_en = RUN && !fifo_empty && issued < BURST_LEN && (occupancy + inflight) < 3`.
  - The condition uses registered occupancy only; it does not look ahead to the same-cycle dequeue.
  - The buffer therefore never overflows.
- Capture: when `inflight` is 1, `fifo_dout` is written at the tail on that clock edge.
- Output: `m_valid = occupancy != 0`. `m_data` is the head entry. `m_last = m_valid && (sent == BURST_LEN-1)`.
- Simultaneous capture and dequeue in one cycle: occupancy is unchanged and both pointers advance, each wrapping from 2 to 0.
- `start` while in RUN: ignored and not queued.
- `start` in the same cycle as the final handshake: ignored. A new burst needs a `start` while in IDLE.
- `fifo_empty` mid-burst: issue stalls, with no bubble beyond the FIFO latency and no error. The burst resumes when `fifo_empty` falls.
- `m_valid`, once high, stays high with `m_data` stable until the handshake.
- Reset mid-burst: all state returns to reset values next cycle. Any in-flight FIFO word is discarded, and any words already read from the FIFO are lost.

## Timing
- Reset values:
  - `busy`=0, `burst_done`=0, `fifo_rd_en`=0, `m_valid`=0, `m_last`=0.
  - `m_data`=0; buffer entries reset to 0.
  - Counters, pointers, occupancy and `inflight` are 0; state is IDLE.
- `start` high in cycle 0 (FIFO non-empty):
  - cycle 1: `busy`=1 and first `fifo_rd_en`=1;
  - cycle 2: FIFO `dout` valid and captured;
  - cycle 3: `m_valid`=1.
- Throughput: with `m_ready` held high and FIFO non-empty, one beat per cycle from cycle 3. An 8-beat burst has its last handshake in cycle 10 and `burst_done` in cycle 11.
- `busy` falls in the same cycle `burst_done` pulses.

## Structure
- Shared package `fifo_pkg` holds:
  - the FSM state enum `rd_state_t` (IDLE, RUN);
  - the constant `SKID_DEPTH` = 3;
  - a function returning counter width from `BURST_LEN`.
- Sub-module `skid_buf3`: 3-entry buffer exposing write/valid/data/ready/occupancy. Counters and FSM stay in the top module.

## Test plan
- Basic burst:
  - stimulus: preload FIFO with 0x24,0x81,0x09,0x63,0x0D,0x8D,0x65,0x12; `m_ready`=1; pulse `start`;
  - response: beats in that order in cycles 3-10, `m_last` only with 0x12, `burst_done` in cycle 11, FIFO `empty`=1 after.
- Backpressure:
  - stimulus: same data, `m_ready` toggled 1,0,0,1,…;
  - response: no beat lost or duplicated, `m_data` stable while `m_valid && !m_ready`, occupancy never exceeds 3.
- Empty stall:
  - stimulus: FIFO holds 3 words at `start`; 5 more written 20 cycles later;
  - response: 3 beats, a gap with `m_valid`=0 and `busy`=1, then the remaining 5 beats, `m_last` on the 8th.
- Ignored start:
  - stimulus: pulse `start` in cycle 5 of a burst, with 16 words in FIFO;
  - response: exactly 8 beats; FIFO retains 8 words; `busy`=0 after.
- Reset mid-burst:
  - stimulus: assert `rst` after the 4th handshake;
  - response: next cycle all outputs at reset values; a following `start` begins a fresh 8-beat count.
- `BURST_LEN`=1:
  - stimulus: single word 0xA5;
  - response: one beat with `m_last`=1, then `burst_done`.
